// File: rtl/shift_console.sv
// Switch/button driven barrel-shifter console: debounced controls, a two-stage
// shift pipeline and a multiplexed hex display of the last result.
module shift_console #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIGITS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic [3:0]        btn,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              result_valid,
  output logic              op_err,
  output logic [2:0]        which,
  output logic [7:0]        seg,
  output logic              enable
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned RF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [8:0]  W9   = 9'(DATA_W);

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  logic [3:0]      sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [4];
  logic [2:0]      db_prev;
  logic [2:0]      pulse_c;

  logic [DATA_W-1:0] data_reg;
  logic [7:0]        amt_reg;
  logic [2:0]        op_reg;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [7:0]        s1_amt;
  logic [2:0]        s1_op;
  logic              s1_c;

  logic [DATA_W-1:0] sh_res_c;
  logic              sh_carry_c;
  logic              bad_op_c;
  logic [8:0]        n9;
  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   lsl_w, lsr_w;
  logic signed [DATA_W:0] asr_w;
  logic [DATA_W-1:0] ror_w;

  logic [RF_W-1:0] rf_cnt;
  logic [3:0]      nib_c;
  logic [7:0]      glyph_c;

  // Synchronise buttons, then accept a new level only after DB_CYCLES agreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db[2:0];
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign pulse_c = db[2:0] & ~db_prev;

  // Operand registers and stage 1; execute samples the pre-load register values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      amt_reg  <= '0;
      op_reg   <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_amt   <= '0;
      s1_op    <= '0;
      s1_c     <= 1'b0;
    end else begin
      if (pulse_c[0]) data_reg <= sw;
      if (pulse_c[1]) begin
        amt_reg <= sw[10:3];
        op_reg  <= sw[2:0];
      end
      s1_valid <= pulse_c[2];
      if (pulse_c[2]) begin
        s1_data <= data_reg;
        s1_amt  <= amt_reg;
        s1_op   <= op_reg;
        s1_c    <= db[3];
      end
    end
  end

  assign n9    = {1'b0, s1_amt};
  assign sh    = s1_amt[SH_W-1:0];
  assign lsl_w = {1'b0, s1_data} << sh;
  assign lsr_w = {s1_data, 1'b0} >> sh;
  assign asr_w = $signed({s1_data, 1'b0}) >>> sh;
  assign ror_w = DATA_W'({s1_data, s1_data} >> sh);

  // Shifter; the extra bit of each widened shift carries the last bit shifted out
  always_comb begin
    sh_res_c   = s1_data;
    sh_carry_c = s1_c;
    bad_op_c   = 1'b0;
    case (s1_op)
      OP_LSL: if (n9 != 9'd0) begin
        if (n9 < W9) begin
          sh_res_c   = lsl_w[DATA_W-1:0];
          sh_carry_c = lsl_w[DATA_W];
        end else begin
          sh_res_c   = '0;
          sh_carry_c = (n9 == W9) ? s1_data[0] : 1'b0;
        end
      end
      OP_LSR: if (n9 != 9'd0) begin
        if (n9 < W9) begin
          sh_res_c   = lsr_w[DATA_W:1];
          sh_carry_c = lsr_w[0];
        end else begin
          sh_res_c   = '0;
          sh_carry_c = (n9 == W9) ? s1_data[DATA_W-1] : 1'b0;
        end
      end
      OP_ASR: if (n9 != 9'd0) begin
        if (n9 < W9) begin
          sh_res_c   = asr_w[DATA_W:1];
          sh_carry_c = asr_w[0];
        end else begin
          sh_res_c   = {DATA_W{s1_data[DATA_W-1]}};
          sh_carry_c = s1_data[DATA_W-1];
        end
      end
      OP_ROR: if (n9 != 9'd0) begin
        if (sh == '0) begin
          sh_carry_c = s1_data[DATA_W-1];
        end else begin
          sh_res_c   = ror_w;
          sh_carry_c = ror_w[DATA_W-1];
        end
      end
      OP_RRX: begin
        sh_res_c   = {s1_c, s1_data[DATA_W-1:1]};
        sh_carry_c = s1_data[0];
      end
      default: bad_op_c = 1'b1;
    endcase
  end

  // Stage 2: registered result, valid pulse and sticky opcode error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      carry_out    <= 1'b0;
      result_valid <= 1'b0;
      op_err       <= 1'b0;
    end else begin
      result_valid <= s1_valid;
      if (s1_valid) begin
        result    <= sh_res_c;
        carry_out <= sh_carry_c;
        if (bad_op_c) op_err <= 1'b1;
      end
    end
  end

  // Digit scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_cnt <= '0;
      which  <= '0;
    end else if (rf_cnt == RF_W'(REFRESH_DIV - 1)) begin
      rf_cnt <= '0;
      which  <= (which == 3'(DIGITS - 1)) ? 3'd0 : which + 3'd1;
    end else begin
      rf_cnt <= rf_cnt + RF_W'(1);
    end
  end

  assign nib_c = 4'(result >> {which, 2'b00});

  always_comb begin
    glyph_c = 8'hFF;
    case (nib_c)
      4'h0: glyph_c = 8'hC0;
      4'h1: glyph_c = 8'hF9;
      4'h2: glyph_c = 8'hA4;
      4'h3: glyph_c = 8'hB0;
      4'h4: glyph_c = 8'h99;
      4'h5: glyph_c = 8'h92;
      4'h6: glyph_c = 8'h82;
      4'h7: glyph_c = 8'hF8;
      4'h8: glyph_c = 8'h80;
      4'h9: glyph_c = 8'h90;
      4'hA: glyph_c = 8'h88;
      4'hB: glyph_c = 8'h83;
      4'hC: glyph_c = 8'hC6;
      4'hD: glyph_c = 8'hA1;
      4'hE: glyph_c = 8'h86;
      default: glyph_c = 8'h8E;
    endcase
  end

  assign seg    = rst ? 8'hFF : glyph_c;
  assign enable = 1'b1;

endmodule

// File: doc/shift_console.md
SHIFT_CONSOLE -- requirements
Module: shift_console

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand and result width (power of two, 8..64); DB_CYCLES, default 1000000, debounce stable-count; REFRESH_DIV, default 100000, clk cycles per display digit; DIGITS, default 8, number of hex digits shown (DIGITS*4 <= DATA_W).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- sw  in  DATA_W  raw switch bank.
- btn  in  4  raw buttons: [0] load data, [1] load control, [2] execute, [3] carry-in level.
- result  out  DATA_W  registered shift result.
- carry_out  out  1  registered shifter carry.
- result_valid  out  1  one-cycle pulse on a new result.
- op_err  out  1  sticky; set by an unsupported opcode.
- which  out  3  active display digit index.
- seg  out  8  active-low segments {dp,g..a}.
- enable  out  1  display enable, constant 1.

Function
REQ-004 Each btn bit SHALL pass a 2-flop synchroniser, then a debouncer that changes state only after DB_CYCLES consecutive identical samples.
REQ-005 btn[0..2] SHALL each produce a one-cycle pulse on the debounced rising edge; btn[3] SHALL be used as a debounced level (carry_in).
REQ-006 The load-data pulse SHALL capture sw into data_reg.
REQ-007 The load-control pulse SHALL capture sw[10:3] into amt_reg (8 bits) and sw[2:0] into op_reg.
REQ-008 When load and execute pulses coincide, execute SHALL use the register values held before that cycle's load.
REQ-009 The execute pulse SHALL latch {data_reg, amt_reg, op_reg, carry_in} into stage 1; stage 2 SHALL register result and carry_out; result_valid SHALL pulse exactly 2 cycles after the execute pulse.
REQ-010 Back-to-back execute pulses SHALL be accepted every cycle, with one result per pulse, in order.
REQ-011 op 000 LSL:
- n=0: data, carry=C.
- 1..W-1: data<<n, carry=data[W-n].
- n=W: 0, carry=data[0].
- n>W: 0, carry=0.
REQ-012 op 001 LSR:
- n=0: data, carry=C.
- 1..W-1: data>>n, carry=data[n-1].
- n=W: 0, carry=data[W-1].
- n>W: 0, carry=0.
REQ-013 op 010 ASR:
- n=0: data, carry=C.
- 1..W-1: arithmetic shift, carry=data[n-1].
- n>=W: all bits=data[W-1], carry=data[W-1].
REQ-014 op 011 ROR:
- n=0: data, carry=C.
- n mod W=0, n!=0: data, carry=data[W-1].
- otherwise: rotate right by n mod W, carry=result[W-1].
REQ-015 op 100 RRX: result={C, data[W-1:1]}, carry=data[0]; amt ignored.
REQ-016 op 101..111: result=data, carry=C, and op_err SHALL set on the cycle the result is produced; only reset clears op_err.
REQ-017 The display SHALL advance which every REFRESH_DIV cycles, counting 0..DIGITS-1 then wrapping to 0.
REQ-018 seg SHALL show the hex glyph of result[4*which+3:4*which], with dp off (seg[7]=1).
REQ-019 The display SHALL be combinational from which and result, with no further latency.

Reset
REQ-020 While rst=1, the following SHALL be 0: data_reg, amt_reg, op_reg, pipeline stages, result, carry_out, result_valid, op_err, debouncer states and counters, refresh counter, and which.
REQ-021 While rst=1, seg SHALL be 8'hFF (blank) and enable SHALL be 1.
REQ-022 A reset asserted mid-pipeline SHALL discard in-flight results; no result_valid pulse SHALL follow the deassertion of rst.

Verification (DB_CYCLES=4, REFRESH_DIV=4, DATA_W=32)
REQ-023 Load data 0x80000001, control amt=1/op=LSL, execute with C=0 -> 2 cycles later result=0x00000002, carry=1, one result_valid pulse.
REQ-024 data 0x80000000, ASR amt=40 -> result=0xFFFFFFFF, carry=1; LSR amt=32 -> result=0, carry=1.
REQ-025 data 0x0000000F: ROR amt=4 -> result=0xF0000000, carry=1; ROR amt=64 -> result=0x0000000F, carry=0; RRX with C=1 -> result=0x80000007, carry=1.
REQ-026 A 2-cycle button glitch -> no capture or pulse; a button held for 10 cycles -> exactly one pulse.
REQ-027 op=110 -> result=data, carry=C, op_err=1 held after later valid ops; rst pulse -> op_err=0.
REQ-028 result=0x0000001A -> which steps 0,1,2.. every 4 cycles with seg(0)=glyph A, seg(1)=glyph 1, and wraps 7->0; rst asserted between execute and valid -> no valid pulse, seg=8'hFF.
